// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM encoding,
// parameter defaults and the per-master request bundle.
package bus_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY0 = 2'd1;
  localparam logic [1:0] ST_BUSY1 = 2'd2;

  localparam int unsigned TIMEOUT_DEFAULT       = 255;
  localparam logic [31:0] TIMEOUT_RDATA_DEFAULT = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_req_t;

endpackage

// File: rtl/bus_arbiter_timer.sv
// Wait counter for a granted transfer; flags the last allowed cycle
// before the arbiter forces completion.
module bus_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);

  logic [15:0] cnt_reg, cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr)
      cnt_next = '0;
    else if (en)
      cnt_next = cnt_reg + 16'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_next;
  end

  assign expired = (cnt_reg == LAST_CNT);

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter between the CPU (m0) and DMA (m1) onto one shared
// slave port, with forced completion when the slave never answers.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT       = TIMEOUT_DEFAULT,
  parameter logic [31:0] TIMEOUT_RDATA = TIMEOUT_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic [1:0]  owner,
  output logic        timeout
);

  logic [1:0]  state_reg, state_next;
  logic        last_reg, last_next;
  logic [1:0]  valid_vec, grant_vec, ready_vec;
  logic [31:0] rdata_vec [2];
  bus_req_t    req_vec [2];
  bus_req_t    s_req;
  logic        busy, own_idx, own_valid, expired, done_ok, done_to;

  assign valid_vec  = {m1_valid, m0_valid};
  assign req_vec[0] = {m0_addr, m0_wdata, m0_wstrb};
  assign req_vec[1] = {m1_addr, m1_wdata, m1_wstrb};

  assign grant_vec = {state_reg == ST_BUSY1, state_reg == ST_BUSY0};
  assign busy      = |grant_vec;
  assign own_idx   = grant_vec[1];
  assign own_valid = |(grant_vec & valid_vec);
  // A slave answer in the expiry cycle still wins over the forced completion
  assign done_ok   = own_valid & s_ready;
  assign done_to   = own_valid & expired & ~s_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      assign ready_vec[gi] = grant_vec[gi] & valid_vec[gi] & (s_ready | expired);
      assign rdata_vec[gi] = !grant_vec[gi] ? 32'd0 :
                             (done_to ? TIMEOUT_RDATA : s_rdata);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    case (state_reg)
      ST_IDLE: begin
        if (m0_valid && m1_valid)
          state_next = last_reg ? ST_BUSY0 : ST_BUSY1;
        else if (m0_valid)
          state_next = ST_BUSY0;
        else if (m1_valid)
          state_next = ST_BUSY1;
      end
      ST_BUSY0, ST_BUSY1: begin
        // A withdrawn request frees the bus without counting as a turn
        if (!own_valid) begin
          state_next = ST_IDLE;
        end else if (done_ok || done_to) begin
          state_next = ST_IDLE;
          last_next  = own_idx;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
      last_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
    end
  end

  bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (!busy),
    .en      (own_valid & ~s_ready),
    .expired (expired)
  );

  assign s_req    = busy ? req_vec[own_idx] : '0;
  assign s_addr   = s_req.addr;
  assign s_wdata  = s_req.wdata;
  assign s_wstrb  = s_req.wstrb;
  assign s_valid  = own_valid & ~done_to;
  assign owner    = grant_vec;
  assign timeout  = done_to;
  assign m0_ready = ready_vec[0];
  assign m1_ready = ready_vec[1];
  assign m0_rdata = rdata_vec[0];
  assign m1_rdata = rdata_vec[1];

endmodule
